// File: rtl/shift_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// shift_sequencer_pkg
// Shared definitions for the shift sequencer and the external Shifter:
//   - Shifter coefficient codes (LEFT2 = left by 1, LEFT4 = left by 2,
//     RIGHT = right by 1). Code 2'b11 is never driven.
//   - FSM state encoding of the sequencer.
//   - Packed record holding the latched direction and remaining distance.
// -----------------------------------------------------------------------------
package shift_sequencer_pkg;

    // Shifter coefficient codes. The names are the Shifter's historic
    // multiplier names: LEFT2 multiplies by 2 (one position left) and
    // LEFT4 multiplies by 4 (two positions left).
    localparam logic [1:0] LEFT2 = 2'b00;
    localparam logic [1:0] LEFT4 = 2'b01;
    localparam logic [1:0] RIGHT = 2'b10;

    // Coefficient driven whenever no shift step is in progress.
    localparam logic [1:0] COEF_IDLE = 2'b00;

    localparam int AMT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Direction (1 = left) plus the distance still to be shifted.
    typedef struct packed {
        logic             dir;
        logic [AMT_W-1:0] cnt;
    } remain_t;

endpackage : shift_sequencer_pkg

// File: rtl/shift_step_sel.sv
// -----------------------------------------------------------------------------
// shift_step_sel
// Combinational choice of the next Shifter step.
// Ports:
//   dir_i    : 1 = left, 0 = right
//   remain_i : distance still to shift (0..7)
//   coef_o   : Shifter coefficient for this step
//   dec_o    : distance covered by this step (1 or 2)
// Right shifts always move one position. Left shifts take two positions
// while at least two remain, finishing an odd distance with a single step.
// -----------------------------------------------------------------------------
module shift_step_sel
    import shift_sequencer_pkg::*;
(
    input  logic             dir_i,
    input  logic [AMT_W-1:0] remain_i,
    output logic [1:0]       coef_o,
    output logic [AMT_W-1:0] dec_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // block leaves a value unassigned, which would infer a latch.
        coef_o = RIGHT;
        dec_o  = AMT_W'(1);
        if (dir_i) begin
            if (remain_i >= AMT_W'(2)) begin
                coef_o = LEFT4;
                dec_o  = AMT_W'(2);
            end else begin
                coef_o = LEFT2;
                dec_o  = AMT_W'(1);
            end
        end
    end

endmodule : shift_step_sel

// File: rtl/shifter.sv
// -----------------------------------------------------------------------------
// shifter
// External combinational Shifter used alongside the sequencer.
// Ports:
//   data_i   : operand
//   coef_i   : LEFT2 = left by 1, LEFT4 = left by 2, RIGHT = right by 1
//   result_o : shifted operand; shifted-out bits are lost, vacated bits are 0
// -----------------------------------------------------------------------------
module shifter
    import shift_sequencer_pkg::*;
#(
    parameter int size = 5
) (
    input  logic [size-1:0] data_i,
    input  logic [1:0]      coef_i,
    output logic [size-1:0] result_o
);

    always_comb begin
        result_o = data_i;
        case (coef_i)
            LEFT2:   result_o = data_i << 1;
            LEFT4:   result_o = data_i << 2;
            RIGHT:   result_o = data_i >> 1;
            default: result_o = data_i;
        endcase
    end

endmodule : shifter

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Drives an external Shifter step by step to shift an operand by 0..7 bits.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   start     : begin an operation (honoured only in IDLE)
//   dir       : 1 = left, 0 = right
//   amount    : total shift distance, 0..7
//   data_in   : operand
//   sh_data   : operand to the Shifter (always the work register)
//   sh_coef   : coefficient to the Shifter (COEF_IDLE outside SHIFT)
//   sh_result : result from the Shifter
//   busy      : high in SHIFT and DONE
//   done      : one-cycle completion pulse (the DONE state)
//   result    : final value, held until the next completion
// -----------------------------------------------------------------------------
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int size = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [AMT_W-1:0] amount,
    input  logic [size-1:0]  data_in,
    output logic [size-1:0]  sh_data,
    output logic [1:0]       sh_coef,
    input  logic [size-1:0]  sh_result,
    output logic             busy,
    output logic             done,
    output logic [size-1:0]  result
);

    state_e          state_q,  state_d;
    logic [size-1:0] work_q,   work_d;
    remain_t         remain_q, remain_d;
    logic [size-1:0] result_q, result_d;
    logic            busy_q,   busy_d;
    logic            done_q,   done_d;

    logic [1:0]       step_coef;
    logic [AMT_W-1:0] step_dec;
    logic [AMT_W-1:0] cnt_next;

    shift_step_sel u_step_sel (
        .dir_i    (remain_q.dir),
        .remain_i (remain_q.cnt),
        .coef_o   (step_coef),
        .dec_o    (step_dec)
    );

    // The selector never asks for more distance than remains, so the
    // subtraction cannot wrap while in SHIFT.
    assign cnt_next = remain_q.cnt - step_dec;

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        remain_d = remain_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d   = data_in;
                    remain_d = '{dir: dir, cnt: amount};
                    busy_d   = 1'b1;
                    if (amount != '0) begin
                        state_d = SHIFT;
                    end else begin
                        // Zero distance: the operand is already the answer.
                        state_d  = DONE;
                        result_d = data_in;
                        done_d   = 1'b1;
                    end
                end
            end

            SHIFT: begin
                work_d       = sh_result;
                remain_d.cnt = cnt_next;
                if (cnt_next == '0) begin
                    // result takes the value the work register is loading now.
                    state_d  = DONE;
                    result_d = sh_result;
                    done_d   = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments throughout sequential logic so
            // every register samples pre-edge values, independent of order.
            state_q  <= IDLE;
            work_q   <= '0;
            remain_q <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            remain_q <= remain_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sh_data = work_q;
    assign sh_coef = (state_q == SHIFT) ? step_coef : COEF_IDLE;
    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
// Table-driven bench for shift_sequencer (size = 5) with an external Shifter.
// Each vector lists operand, direction, distance and the hand-worked result,
// step count and coefficient sequence. Hand-written sequences cover start
// during SHIFT, reset mid-SHIFT and start coincident with reset.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         dir;
    logic [2:0]   amount;
    logic [W-1:0] data_in;
    logic [W-1:0] sh_data;
    logic [1:0]   sh_coef;
    logic [W-1:0] sh_result;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.size(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dir       (dir),
        .amount    (amount),
        .data_in   (data_in),
        .sh_data   (sh_data),
        .sh_coef   (sh_coef),
        .sh_result (sh_result),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    shifter #(.size(W)) u_shifter (
        .data_i   (sh_data),
        .coef_i   (sh_coef),
        .result_o (sh_result)
    );

    typedef struct {
        logic         dir;
        logic [2:0]   amount;
        logic [W-1:0] data;
        logic [W-1:0] exp_result;
        int           exp_steps;
        logic [1:0]   exp_coef [4];
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation and follow it to completion, checking the step
    // coefficients, latency, busy span, result and the return to IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        logic [1:0] got [8];
        int         steps;
        int         busy_cycles;
        bit         seen_done;

        @(negedge clk);
        dir     = v.dir;
        amount  = v.amount;
        data_in = v.data;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;

        steps       = 0;
        busy_cycles = 0;
        seen_done   = 1'b0;
        if (v.exp_steps > 0)
            check($sformatf("%s_sh_data_first", tag), 32'(sh_data), 32'(v.data));

        for (int c = 0; c < 20 && !seen_done; c++) begin
            if (busy) busy_cycles++;
            if (done) begin
                seen_done = 1'b1;
            end else begin
                if (steps < 8) got[steps] = sh_coef;
                steps++;
                @(negedge clk);
            end
        end

        check($sformatf("%s_done_seen", tag), 32'(seen_done), 32'd1);
        check($sformatf("%s_steps", tag), 32'(steps), 32'(v.exp_steps));
        check($sformatf("%s_busy_cycles", tag), 32'(busy_cycles), 32'(v.exp_steps + 1));
        check($sformatf("%s_result", tag), 32'(result), 32'(v.exp_result));
        for (int i = 0; i < 4; i++) begin
            if (i < v.exp_steps && i < steps)
                check($sformatf("%s_coef%0d", tag, i), 32'(got[i]), 32'(v.exp_coef[i]));
        end

        @(negedge clk);
        check($sformatf("%s_done_one_cycle", tag), 32'(done), 32'd0);
        check($sformatf("%s_idle_busy", tag), 32'(busy), 32'd0);
        check($sformatf("%s_idle_coef", tag), 32'(sh_coef), 32'd0);
        check($sformatf("%s_result_hold", tag), 32'(result), 32'(v.exp_result));
    endtask

    initial begin
        int done_count;

        rst     = 1'b1;
        start   = 1'b0;
        dir     = 1'b0;
        amount  = 3'd0;
        data_in = '0;

        //            dir   amt   data      result    N  coefficients
        vecs[0] = '{1'b1, 3'd3, 5'b00011, 5'b11000, 2, '{2'b01, 2'b00, 2'b00, 2'b00}};
        vecs[1] = '{1'b0, 3'd2, 5'b10110, 5'b00101, 2, '{2'b10, 2'b10, 2'b00, 2'b00}};
        vecs[2] = '{1'b1, 3'd0, 5'b10101, 5'b10101, 0, '{2'b00, 2'b00, 2'b00, 2'b00}};
        vecs[3] = '{1'b1, 3'd7, 5'b00001, 5'b00000, 4, '{2'b01, 2'b01, 2'b01, 2'b00}};
        vecs[4] = '{1'b0, 3'd3, 5'b11010, 5'b00011, 3, '{2'b10, 2'b10, 2'b10, 2'b00}};
        vecs[5] = '{1'b1, 3'd2, 5'b00111, 5'b11100, 1, '{2'b01, 2'b00, 2'b00, 2'b00}};
        vecs[6] = '{1'b1, 3'd1, 5'b10011, 5'b00110, 1, '{2'b00, 2'b00, 2'b00, 2'b00}};
        vecs[7] = '{1'b0, 3'd1, 5'b00001, 5'b00000, 1, '{2'b10, 2'b00, 2'b00, 2'b00}};
        vecs[8] = '{1'b1, 3'd4, 5'b00011, 5'b10000, 2, '{2'b01, 2'b01, 2'b00, 2'b00}};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_sh_coef", 32'(sh_coef), 32'd0);
        check("rst_sh_data", 32'(sh_data), 32'd0);
        check("rst_result",  32'(result),  32'd0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // start pulsed during SHIFT with different data must be ignored.
        @(negedge clk);
        dir = 1'b0; amount = 3'd2; data_in = 5'b10110; start = 1'b1;
        @(negedge clk);
        check("ign_in_shift", 32'(busy), 32'd1);
        dir = 1'b1; amount = 3'd0; data_in = 5'b11111;
        @(negedge clk);
        start = 1'b0;
        done_count = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) begin
                done_count++;
                check("ign_result", 32'(result), 32'(5'b00101));
            end
            @(negedge clk);
        end
        check("ign_single_done", 32'(done_count), 32'd1);
        check("ign_idle_after", 32'(busy), 32'd0);
        check("ign_result_hold", 32'(result), 32'(5'b00101));

        // Reset mid-SHIFT: abort, zero state, no done pulse.
        @(negedge clk);
        dir = 1'b1; amount = 3'd7; data_in = 5'b00001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_in_shift", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy",    32'(busy),    32'd0);
        check("abort_done",    32'(done),    32'd0);
        check("abort_result",  32'(result),  32'd0);
        check("abort_sh_data", 32'(sh_data), 32'd0);
        check("abort_sh_coef", 32'(sh_coef), 32'd0);
        rst = 1'b0;
        done_count = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) done_count++;
        end
        check("abort_no_done", 32'(done_count), 32'd0);
        check("abort_still_idle", 32'(busy), 32'd0);
        run_vec(vecs[0], "after_abort");

        // start coincident with rst must be ignored.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; dir = 1'b0; amount = 3'd0; data_in = 5'b11011;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy",    32'(busy),    32'd0);
        check("rst_start_sh_data", 32'(sh_data), 32'd0);
        @(negedge clk);
        check("rst_start_busy2", 32'(busy), 32'd0);
        check("rst_start_done2", 32'(done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_shift_sequencer

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have exactly one parameter: size, default 5, data width in bits.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a shift operation.
- dir  input  1  shift direction: 1 = left, 0 = right.
- amount  input  3  total shift distance in bits, 0..7.
- data_in  input  size  operand to be shifted.
- sh_data  output  size  operand driven to the external Shifter data input.
- sh_coef  output  2  code driven to the external Shifter coefficient input.
- sh_result  input  size  result returned by the external Shifter.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- result  output  size  final shifted value.
REQ-003 sh_coef encodings SHALL be 2'b00 = left by 1, 2'b01 = left by 2, 2'b10 = right by 1; 2'b11 SHALL never be driven.

Function
REQ-004 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-005 In IDLE, start=1 SHALL latch data_in into a work register, and latch dir and amount into a remaining-count register.
- On that start, the FSM SHALL go to SHIFT if amount != 0, otherwise to DONE.
REQ-006 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-007 In each SHIFT cycle, the coefficient SHALL be chosen as follows:
- dir=0: sh_coef = right by 1; remaining decreases by 1.
- dir=1 and remaining >= 2: sh_coef = left by 2; remaining decreases by 2.
- dir=1 and remaining = 1: sh_coef = left by 1; remaining decreases by 1.
REQ-008 sh_data SHALL always equal the work register.
- In SHIFT, the work register SHALL load sh_result at each rising edge.
REQ-009 sh_coef SHALL be 2'b00 outside SHIFT.
REQ-010 SHIFT SHALL go to DONE when the decremented remaining count reaches 0; otherwise the FSM SHALL stay in SHIFT.
REQ-011 Step count N SHALL be amount for right shifts, and floor(amount/2) + amount mod 2 for left shifts.
REQ-012 Latency: with start sampled at edge k, done SHALL be high in the cycle following edge k+N; N=0 gives done in the cycle after edge k.
REQ-013 On the transition into DONE, result SHALL load the work register value.
- result SHALL hold that value until the next transition into DONE.
REQ-014 done SHALL be high only in DONE, for exactly one cycle; DONE SHALL always go to IDLE.
REQ-015 busy SHALL be high in SHIFT and DONE, and low in IDLE.
REQ-016 Bits shifted out SHALL be discarded, and vacated bits SHALL be zero-filled, as produced by the Shifter.
- No saturation and no overflow flag.

Reset
REQ-017 rst=1 at a rising edge SHALL force state IDLE and zero the work register, the remaining count and result, from any state including mid-SHIFT.
REQ-018 While rst=1, outputs SHALL be busy=0, done=0, sh_coef=2'b00, sh_data=0 and result=0; an aborted operation SHALL NOT produce done.
REQ-019 start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-020 Shifter coefficient constants (LEFT2=2'b00, LEFT4=2'b01, RIGHT=2'b10) and the FSM state encodings SHALL reside in one shared header.
- That header SHALL be used by this block and by the Shifter.
REQ-021 The Shifter SHALL remain external; the enclosing datapath connects sh_data, sh_coef and sh_result.
REQ-022 Step selection (dir and remaining in; coefficient and decrement out) SHALL be a combinational sub-module named shift_step_sel.

Verification
REQ-023 Benches SHALL use size=5, an external Shifter instance, and cover these scenarios:
- dir=1, amount=3, data_in=5'b00011 -> sh_coef sequence 01, 00; result=5'b11000; done 3 cycles after the start cycle.
- dir=0, amount=2, data_in=5'b10110 -> sh_coef 10, 10; result=5'b00101; busy high for 3 cycles.
- amount=0, data_in=5'b10101 -> no SHIFT cycles; done in the next cycle; result=5'b10101.
- dir=1, amount=7, data_in=5'b00001 -> four steps (01, 01, 01, 00); result=5'b00000.
- start pulsed during SHIFT with different data -> ignored; the first operation's result is unchanged.
- rst asserted mid-SHIFT -> next cycle IDLE, busy=0, result=0, no done pulse; a following operation completes correctly.
